// File: rtl/sync_frame_serializer_if.sv
// sync_frame_serializer_if: payload valid/ready handshake into the 11011 sync-word serializer.
interface sync_frame_serializer_if #(parameter int PAYLOAD_W = 8);
    logic [PAYLOAD_W-1:0] data_in;
    logic                 data_valid;
    logic                 data_ready;
    modport master (output data_in, data_valid, input data_ready);
    modport slave  (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/sync_frame_serializer.sv
// sync_frame_serializer: sends 11011 sync, payload MSB-first, then GAP_LEN zero guard bits.
module sync_frame_serializer #(
    parameter int         PAYLOAD_W = 8,
    parameter int         GAP_LEN   = 2,
    parameter logic [4:0] SYNC_WORD = 5'b11011
) (
    input  logic                     clk,
    input  logic                     rst,
    sync_frame_serializer_if.slave   bus,
    output logic                     serial_out,
    output logic                     frame_active,
    output logic                     sync_active,
    output logic                     done
);
    localparam int CW = $clog2(PAYLOAD_W + 1);
    localparam logic [CW-1:0] P_LAST = CW'(PAYLOAD_W - 1);
    localparam logic [3:0] G_LAST = 4'(GAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, GAP} state_t;

    state_t               state, state_d;
    logic [2:0]           idx, idx_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [3:0]           gcnt, gcnt_d;
    logic [PAYLOAD_W-1:0] shift, shift_d;
    logic                 serial_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            gcnt       <= '0;
            shift      <= '0;
            serial_out <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            gcnt       <= gcnt_d;
            shift      <= shift_d;
            serial_out <= serial_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        gcnt_d  = gcnt;
        shift_d = shift;
        case (state)
            IDLE: if (bus.data_valid) begin
                state_d = SYNC;
                idx_d   = 3'd4;
                shift_d = bus.data_in;
            end
            SYNC: if (idx == 3'd0) begin
                state_d = PAYLOAD;
                cnt_d   = '0;
            end else idx_d = idx - 3'd1;
            PAYLOAD: begin
                shift_d = shift << 1;
                if (cnt == P_LAST) begin
                    state_d = GAP;
                    gcnt_d  = '0;
                end else cnt_d = cnt + CW'(1);
            end
            default: if (gcnt == G_LAST) state_d = IDLE;
                     else gcnt_d = gcnt + 4'd1;
        endcase
        // the line register is loaded with the bit belonging to the state being entered
        serial_d = state_d == SYNC ? SYNC_WORD[idx_d] :
                   state_d == PAYLOAD ? shift_d[PAYLOAD_W-1] : 1'b0;
    end

    assign bus.data_ready = state == IDLE;
    assign frame_active   = state == SYNC || state == PAYLOAD;
    assign sync_active    = state == SYNC;
    assign done           = state == PAYLOAD && cnt == P_LAST;
endmodule

// File: tb/tb_sync_frame_serializer.sv
// tb_sync_frame_serializer: random and directed frames checked against a per-cycle expected-symbol queue.
module tb_sync_frame_serializer;
    localparam int W = 8;
    localparam int G = 2;
    localparam logic [4:0] IDLE_E = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_out, frame_active, sync_active, done;
    sync_frame_serializer_if #(.PAYLOAD_W(W)) bus ();

    sync_frame_serializer #(.PAYLOAD_W(W), .GAP_LEN(G)) dut (
        .clk(clk), .rst(rst), .bus(bus), .serial_out(serial_out),
        .frame_active(frame_active), .sync_active(sync_active), .done(done));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t_hs = 0;
    int t_prev = 0;
    int hits = 0;
    int hit_cyc = 0;
    logic [14:0] hist = '0;
    logic [4:0] det = '0;
    // expected {serial, frame, sync, done, ready} per cycle
    logic [4:0] cur = IDLE_E;
    logic [4:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        logic [4:0] sw;
        sw = 5'b11011;
        for (int i = 4; i >= 0; i--) q.push_back({sw[i], 4'b1100});
        for (int i = W - 1; i >= 0; i--) q.push_back({d[i], 2'b10, i == 0, 1'b0});
        for (int i = 0; i < G; i++) q.push_back(5'b00000);
        t_prev = t_hs;
        t_hs = cyc;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        cyc++;
        chk("line", serial_out, cur[4]);
        chk("flags", {frame_active, sync_active, done, bus.data_ready}, cur[3:0]);
        hist = {hist[13:0], serial_out};
        det = {det[3:0], serial_out};
        if (det == 5'b11011) begin
            hits++;
            hit_cyc = cyc;
        end
        bus.data_valid = v;
        bus.data_in = d;
        if (!rst) begin
            q.delete();
            cur = IDLE_E;
        end else begin
            if (cur[0] && v) push_frame(d);
            cur = q.size() != 0 ? q.pop_front() : IDLE_E;
        end
    endtask

    initial begin
        bus.data_valid = 1'b0;
        bus.data_in = '0;
        #1 rst = 1'b0;
        repeat (3) step(1'b0, 8'h00);
        rst = 1'b1;
        repeat (6) step(1'b0, W'($urandom));

        step(1'b1, 8'hA5);
        repeat (15) step(1'b0, W'($urandom));
        chk("a5_bits", hist, 15'b110111010010100);
        step(1'b0, 8'h00);
        chk("a5_ready_t16", bus.data_ready, 1'b1);

        step(1'b1, 8'h00);
        repeat (16) step(1'b1, 8'hFF);
        chk("b2b_period", t_hs - t_prev, 16);
        repeat (17) step(1'b0, W'($urandom));

        hits = 0;
        step(1'b1, 8'h00);
        repeat (18) step(1'b0, 8'h00);
        chk("det_hits", hits, 1);
        chk("det_cycle", hit_cyc - t_hs, 5);

        step(1'b1, 8'h3C);
        repeat (10) step(1'b0, W'($urandom));
        rst = 1'b0;
        #1;
        chk("rst_line", serial_out, 1'b0);
        chk("rst_frame", frame_active, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", bus.data_ready, 1'b1);
        q.delete();
        cur = IDLE_E;
        repeat (2) step(1'b0, 8'h00);
        rst = 1'b1;
        hits = 0;
        step(1'b0, 8'h00);
        step(1'b1, 8'h5A);
        repeat (16) step(1'b0, 8'h00);
        chk("rst_resync_hits", hits, 1);

        repeat (500) step($urandom_range(0, 2) != 0, W'($urandom));
        repeat (20) step(1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
